// File: rtl/cordic_pre_stage.sv
// cordic_pre_stage: reduces requests to quadrant 0 and carries the quadrant tag to the chain end.
// Define CORDIC_PRE_SAT_EN to saturate negation of the most negative value.
module cordic_pre_stage #(
  parameter int BIT_WIDTH = 16,
  parameter int X_INIT    = 19898,
  parameter int TAG_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_mode,
  input  logic [BIT_WIDTH+1:0]        req_angle,
  input  logic signed [BIT_WIDTH-1:0] req_x,
  input  logic signed [BIT_WIDTH-1:0] req_y,
  output logic signed [BIT_WIDTH-1:0] out_target_angle,
  output logic signed [BIT_WIDTH:0]   out_current_angle,
  output logic signed [BIT_WIDTH-1:0] out_x,
  output logic signed [BIT_WIDTH-1:0] out_y,
  output logic                        out_mode,
  output logic                        out_done,
  output logic [1:0]                  tag_quadrant,
  output logic                        tag_valid
);

  localparam logic signed [BIT_WIDTH-1:0] XI = BIT_WIDTH'(X_INIT);

  function automatic logic signed [BIT_WIDTH-1:0] neg(
    input logic signed [BIT_WIDTH-1:0] v
  );
    logic signed [BIT_WIDTH-1:0] r;
    r = -v;
`ifdef CORDIC_PRE_SAT_EN
    if (v == {1'b1, {(BIT_WIDTH-1){1'b0}}}) begin
      r = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    end
`endif
    return r;
  endfunction

  logic signed [BIT_WIDTH-1:0] tgt_q, tgt_d;
  logic signed [BIT_WIDTH:0]   cur_q, cur_d;
  logic signed [BIT_WIDTH-1:0] x_q, x_d;
  logic signed [BIT_WIDTH-1:0] y_q, y_d;
  logic                        mode_q, mode_d;
  logic                        done_q, done_d;
  logic [2:0]                  tag_q [TAG_DEPTH+1];
  logic [2:0]                  tag_d [TAG_DEPTH+1];

  logic                        xfer;
  logic                        xs, ys;
  logic [1:0]                  vq, q;
  logic signed [BIT_WIDTH-1:0] vx, vy;

  assign req_ready = start & ~reset;
  assign xfer      = req_valid & req_ready;
  assign xs        = req_x[BIT_WIDTH-1];
  assign ys        = req_y[BIT_WIDTH-1];

  // Rotate the vector by -q*90 degrees so it lands in quadrant 0.
  always_comb begin
    vq = 2'd0;
    vx = req_x;
    vy = req_y;
    unique case (1'b1)
      (!xs && !ys): begin
        vq = 2'd0;
        vx = req_x;
        vy = req_y;
      end
      (xs && !ys): begin
        vq = 2'd1;
        vx = req_y;
        vy = neg(req_x);
      end
      (xs && ys): begin
        vq = 2'd2;
        vx = neg(req_x);
        vy = neg(req_y);
      end
      (!xs && ys): begin
        vq = 2'd3;
        vx = neg(req_y);
        vy = req_x;
      end
    endcase
  end

  assign q = req_mode ? vq : req_angle[BIT_WIDTH+1:BIT_WIDTH];

  always_comb begin
    tgt_d  = tgt_q;
    cur_d  = cur_q;
    x_d    = x_q;
    y_d    = y_q;
    mode_d = mode_q;
    done_d = done_q;
    tag_d  = tag_q;
    if (start) begin
      done_d = xfer;
      if (xfer) begin
        mode_d = req_mode;
        cur_d  = '0;
        if (req_mode) begin
          tgt_d = '0;
          x_d   = vx;
          y_d   = vy;
        end else begin
          tgt_d = req_angle[BIT_WIDTH-1:0];
          x_d   = XI;
          y_d   = '0;
        end
      end
      tag_d[0] = {xfer, q};
      for (int i = 1; i <= TAG_DEPTH; i++) begin
        tag_d[i] = tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_q  <= '0;
      cur_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i <= TAG_DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tgt_q  <= tgt_d;
      cur_q  <= cur_d;
      x_q    <= x_d;
      y_q    <= y_d;
      mode_q <= mode_d;
      done_q <= done_d;
      tag_q  <= tag_d;
    end
  end

  assign out_target_angle  = tgt_q;
  assign out_current_angle = cur_q;
  assign out_x             = x_q;
  assign out_y             = y_q;
  assign out_mode          = mode_q;
  assign out_done          = done_q;
  assign tag_valid         = tag_q[TAG_DEPTH][2];
  assign tag_quadrant      = tag_q[TAG_DEPTH][1:0];

endmodule

// File: tb/tb_cordic_pre_stage.sv
// tb_cordic_pre_stage: directed plus random stimulus against a quadrant-reduction model.
// Expected saturation behaviour follows CORDIC_PRE_SAT_EN.
module tb_cordic_pre_stage;

  localparam int BW = 16;
  localparam int XI = 19898;
  localparam int TD = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_mode;
  logic [BW+1:0]        req_angle;
  logic signed [BW-1:0] req_x;
  logic signed [BW-1:0] req_y;
  logic signed [BW-1:0] out_target_angle;
  logic signed [BW:0]   out_current_angle;
  logic signed [BW-1:0] out_x;
  logic signed [BW-1:0] out_y;
  logic                 out_mode;
  logic                 out_done;
  logic [1:0]           tag_quadrant;
  logic                 tag_valid;

  always #5 clk = ~clk;

  cordic_pre_stage #(
    .BIT_WIDTH(BW),
    .X_INIT(XI),
    .TAG_DEPTH(TD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_mode(req_mode),
    .req_angle(req_angle),
    .req_x(req_x),
    .req_y(req_y),
    .out_target_angle(out_target_angle),
    .out_current_angle(out_current_angle),
    .out_x(out_x),
    .out_y(out_y),
    .out_mode(out_mode),
    .out_done(out_done),
    .tag_quadrant(tag_quadrant),
    .tag_valid(tag_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;

  logic signed [BW-1:0] m_tgt, m_x, m_y;
  logic                 m_mode, m_done;
  logic [2:0]           m_tags[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic signed [BW-1:0] fit(input int v);
    if (v == 32768) begin
`ifdef CORDIC_PRE_SAT_EN
      return 16'sd32767;
`else
      return 16'sh8000;
`endif
    end
    return BW'(v);
  endfunction

  task automatic model_reset();
    m_tgt  = '0;
    m_x    = '0;
    m_y    = '0;
    m_mode = 1'b0;
    m_done = 1'b0;
    m_tags = {};
    for (int i = 0; i <= TD; i++) m_tags.push_back(3'b000);
  endtask

  task automatic model_step(input bit rst, input bit st, input bit v,
                            input bit md, input logic [BW+1:0] ang,
                            input int xi, input int yi);
    int       q, mx, my;
    bit       acc;
    if (rst) begin
      model_reset();
      return;
    end
    if (!st) return;
    acc = v;
    if (xi >= 0 && yi >= 0) begin
      q = 0; mx = xi; my = yi;
    end else if (xi < 0 && yi >= 0) begin
      q = 1; mx = yi; my = -xi;
    end else if (xi < 0) begin
      q = 2; mx = -xi; my = -yi;
    end else begin
      q = 3; mx = -yi; my = xi;
    end
    if (!md) q = int'(ang[BW+1:BW]);
    m_done = acc;
    if (acc) begin
      n_acc++;
      m_mode = md;
      if (md) begin
        m_tgt = '0;
        m_x   = fit(mx);
        m_y   = fit(my);
      end else begin
        m_tgt = ang[BW-1:0];
        m_x   = BW'(XI);
        m_y   = '0;
      end
    end
    m_tags.push_front({acc, 2'(q)});
    void'(m_tags.pop_back());
  endtask

  task automatic step(input bit rst, input bit st, input bit v,
                      input bit md, input logic [BW+1:0] ang,
                      input logic signed [BW-1:0] x,
                      input logic signed [BW-1:0] y);
    reset     = rst;
    start     = st;
    req_valid = v;
    req_mode  = md;
    req_angle = ang;
    req_x     = x;
    req_y     = y;
    #1;
    chk("req_ready", 32'(req_ready), 32'(st & ~rst));
    model_step(rst, st, v, md, ang, int'(x), int'(y));
    @(posedge clk);
    #1;
    chk("done", 32'(out_done), 32'(m_done));
    chk("cur", 32'(out_current_angle), 32'd0);
    chk("tag_valid", 32'(tag_valid), 32'(m_tags[TD][2]));
    if (m_tags[TD][2]) chk("tag_q", 32'(tag_quadrant), 32'(m_tags[TD][1:0]));
    if (m_done) begin
      chk("mode", 32'(out_mode), 32'(m_mode));
      chk("tgt", 32'(out_target_angle), 32'(m_tgt));
      chk("x", 32'(out_x), 32'(m_x));
      chk("y", 32'(out_y), 32'(m_y));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, '0, '0, '0);
  endtask

  task automatic vec(input logic signed [BW-1:0] x,
                     input logic signed [BW-1:0] y);
    step(0, 1, 1, 1, '0, x, y);
  endtask

  initial begin
    int       lat;
    int       acc0;
    bit       p_v, p_m, st, rs;
    logic [BW+1:0]        p_a;
    logic signed [BW-1:0] p_x, p_y;
    logic signed [BW-1:0] fx, fy;
    logic signed [BW-1:0] sx, sy;

    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 18'h1_2000, '0, '0);
    chk("rst_x", 32'(out_x), 32'd0);
    chk("rst_tgt", 32'(out_target_angle), 32'd0);
    idle(TD + 2);

    step(0, 1, 1, 0, 18'h1_2000, '0, '0);
    chk("rot_tgt", 32'(out_target_angle), 32'h2000);
    chk("rot_x", 32'(out_x), 32'd19898);
    chk("rot_y", 32'(out_y), 32'd0);
    lat = 1;
    while (!tag_valid && lat < 40) begin
      idle(1);
      lat++;
    end
    chk("tag_lat", 32'(lat), 32'(TD + 1));
    chk("tag_quad", 32'(tag_quadrant), 32'd1);

    vec(-16'sd100, 16'sd50);
    chk("v1_x", 32'(out_x), 32'(16'sd50));
    chk("v1_y", 32'(out_y), 32'(16'sd100));
    vec(-16'sd100, -16'sd50);
    chk("v2_x", 32'(out_x), 32'(16'sd100));
    chk("v2_y", 32'(out_y), 32'(16'sd50));
    vec(16'sd0, -16'sd1);
    chk("v3_x", 32'(out_x), 32'(16'sd1));
    chk("v3_y", 32'(out_y), 32'(16'sd0));
    vec(16'sd0, 16'sd0);
    chk("v4_x", 32'(out_x), 32'(16'sd0));
    vec(16'sh8000, 16'sd0);
`ifdef CORDIC_PRE_SAT_EN
    chk("v5_y", 32'(out_y), 32'(16'sd32767));
`else
    chk("v5_y", 32'(out_y), 32'(16'sh8000));
`endif
    idle(TD);
    chk("v_tag4", 32'(tag_quadrant), 32'd1);

    acc0 = n_acc;
    vec(16'sd7, -16'sd9);
    sx = out_x;
    sy = out_y;
    step(0, 0, 1, 1, '0, 16'sd3, 16'sd4);
    step(0, 0, 1, 1, '0, 16'sd3, 16'sd4);
    chk("frz_x", 32'(out_x), 32'(sx));
    chk("frz_y", 32'(out_y), 32'(sy));
    step(0, 1, 1, 1, '0, 16'sd3, 16'sd4);
    chk("acc_cnt", 32'(n_acc - acc0), 32'd2);
    step(1, 1, 1, 1, '0, 16'sd3, 16'sd4);
    chk("mid_rst_done", 32'(out_done), 32'd0);
    chk("mid_rst_tag", 32'(tag_valid), 32'd0);

    p_v = 0; p_m = 0; p_a = '0; p_x = '0; p_y = '0;
    for (int c = 0; c < 600; c++) begin
      if (!p_v) begin
        p_v = ($urandom_range(0, 3) != 0);
        p_m = $urandom_range(0, 1) == 1;
        p_a = 18'($urandom);
        fx = 16'($urandom);
        fy = 16'($urandom);
        case ($urandom_range(0, 5))
          0: fx = 16'sh8000;
          1: fy = 16'sh8000;
          2: fx = '0;
          3: fy = '0;
          default: ;
        endcase
        p_x = fx;
        p_y = fy;
      end
      st = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 49) == 0);
      step(rs, st, p_v, p_m, p_a, p_x, p_y);
      if (st && !rs) p_v = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_pre_stage.md
Name: cordic_pre_stage

Overview:
- Front-end stage of the pipelined CORDIC; directly feeds stage 0 of the cordic_stage chain.
- Accepts a rotation-mode or vectoring-mode request through a valid/ready handshake and reduces it to the first quadrant.
- Drives stage-0 inputs: target angle, zeroed current angle, initial x/y, mode, done.
- Carries the 2-bit quadrant code through a tag delay line aligned to the stage chain, so the output stage can undo the reduction.

Parameters:
- BIT_WIDTH, 16: data/angle width; must match the stage chain.
- X_INIT, 19898: rotation-mode initial x (CORDIC gain-compensated unit vector, 0.60725 scaled to 2^(BIT_WIDTH-1)-1); must be < 2^(BIT_WIDTH-1).
- TAG_DEPTH, 16: number of cordic_stage instances downstream, ≥1.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  global pipeline advance, shared with every stage.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted this cycle.
- req_mode  input  1  0 = rotation, 1 = vectoring.
- req_angle  input  BIT_WIDTH+2  rotation angle, unsigned full circle; [BIT_WIDTH+1:BIT_WIDTH] = quadrant, [BIT_WIDTH-1:0] = angle within quadrant.
- req_x  input  BIT_WIDTH signed  vectoring x.
- req_y  input  BIT_WIDTH signed  vectoring y.
- out_target_angle  output  BIT_WIDTH signed  to stage 0.
- out_current_angle  output  BIT_WIDTH+1 signed  to stage 0.
- out_x  output  BIT_WIDTH signed  to stage 0.
- out_y  output  BIT_WIDTH signed  to stage 0.
- out_mode  output  1  to stage 0.
- out_done  output  1  to stage 0; 1 = real data, 0 = bubble.
- tag_quadrant  output  2  quadrant code aligned with the last stage output.
- tag_valid  output  1  tag_quadrant belongs to a real result.

Behaviour:
- Reset: all outputs and every tag-line entry = 0; req_ready = 0 while reset is high.
- req_ready = start & ~reset (combinational). A transfer occurs on req_valid & req_ready.
- start low: all registers hold; no transfer.
- start high, no transfer: out_done <= 0 (bubble). Other stage-0 outputs are don't-care but must hold their previous values, to save power.
- start high with a transfer: registers load, giving a latency of 1 cycle. Loaded values:
  - out_done <= 1
  - out_mode <= req_mode
  - out_current_angle <= 0
- Rotation mode loads:
  - q = req_angle[top two bits]
  - out_target_angle <= req_angle[BIT_WIDTH-1:0]
  - out_x <= X_INIT
  - out_y <= 0
- Vectoring mode: quadrant q from signs; "≥0" includes zero.
  - q=0 when x≥0, y≥0: map (x,y).
  - q=1 when x<0, y≥0: map (y,−x).
  - q=2 when x<0, y<0: map (−x,−y).
  - q=3 when x≥0, y<0: map (−y,x).
  - Loads: out_target_angle <= 0; out_x, out_y <= the mapped pair.
- Negation width: BIT_WIDTH two's complement; behaviour for −2^(BIT_WIDTH-1) is set by the optional feature below.
- Tag line: TAG_DEPTH+1 entries, each {valid, quadrant}.
  - Shifts only when start is high; entry 0 loads {transfer, q}.
  - {tag_valid, tag_quadrant} = last entry.
  - A tag therefore emerges on the same cycle its result leaves the last cordic_stage.
- Reset mid-operation: the tag line clears and out_done clears in the same cycle; all in-flight tags are lost.
- req_valid while start is low: no acceptance; the requester must hold the request (standard valid/ready; valid must not drop before acceptance).

Optional Feature:
- Macro: CORDIC_PRE_SAT_EN.
- Defined: negating −2^(BIT_WIDTH-1) saturates to 2^(BIT_WIDTH-1)−1.
- Undefined: plain two's-complement negation, so −2^(BIT_WIDTH-1) stays −2^(BIT_WIDTH-1) (wraps). Saves a comparator per path.

Test Plan:
- Reset, then start=1, req_valid=0 -> out_done=0, tag_valid=0 for TAG_DEPTH+2 cycles, req_ready=1.
- Rotation, req_angle=18'h1_2000 with start held high -> next cycle: out_target_angle=16'h2000, out_x=19898, out_y=0, out_current_angle=0, out_done=1; tag_valid=1, tag_quadrant=1 exactly TAG_DEPTH+1 cycles after acceptance.
- Vectoring x=−100, y=50 -> out_x=50, out_y=100, q=1. Vectoring x=−100, y=−50 -> out_x=100, out_y=50, q=2.
- Vectoring x=0, y=−1 -> q=3, out_x=1, out_y=0. Vectoring x=0, y=0 -> q=0, out_x=0, out_y=0.
- Vectoring x=−32768, y=0 -> q=1, out_y=32767 with CORDIC_PRE_SAT_EN; out_y=−32768 without.
- start toggled 1,0,0,1 with req_valid held high -> exactly 2 acceptances; outputs and tag line frozen during start=0. Reset asserted mid-stream -> out_done=0, tag_valid=0 on the next cycle.
